// File: rtl/cache_refill_pkg.sv
// Shared types and constants for the cache line refill/writeback engine.
package cache_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_AW,
    WB_W,
    WB_B,
    RD_AR,
    RD_R,
    RESP
  } refill_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Clears the byte-offset bits of a line; line_words must be a power of two.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned line_words);
    logic [63:0] mask;
    mask = 64'(line_words * 4) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// One cache line of storage: parallel load of the victim, per-word fill, flat read.
module refill_line_buffer #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [LINE_WORDS*32-1:0]      load_data_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_idx_i,
  input  logic [31:0]                   wr_data_i,
  output logic [LINE_WORDS*32-1:0]      line_o
);

  logic [31:0] word_q [LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) word_q[i] <= '0;
    end else if (load_i) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) word_q[i] <= load_data_i[i*32 +: 32];
    end else if (wr_en_i) begin
      word_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    line_o = '0;
    for (int unsigned i = 0; i < LINE_WORDS; i++) line_o[i*32 +: 32] = word_q[i];
  end

endmodule

// File: rtl/nway_line_refill_axi.sv
// Miss handler: optional victim writeback burst, then line fill burst, then line return.
module nway_line_refill_axi
  import cache_refill_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic                     req_wb,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [LINE_WORDS*32-1:0] wb_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [LINE_WORDS*32-1:0] resp_data,
  output logic                     resp_err,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  input  logic [1:0]               bresp,
  output logic                     bready,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  input  logic                     rvalid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  output logic                     rready
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W = IDX_W + 1;

  refill_state_e           state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    live_q;
  logic [ADDR_W-1:0]       awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]       araddr_q, araddr_d;
  logic                    buf_load, buf_wr;
  logic [LINE_WORDS*32-1:0] line;
  logic                    is_last;

  refill_line_buffer #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (buf_load),
    .load_data_i (wb_data),
    .wr_en_i     (buf_wr),
    .wr_idx_i    (cnt_q[IDX_W-1:0]),
    .wr_data_i   (rdata),
    .line_o      (line)
  );

  assign is_last = (cnt_q == CNT_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    buf_load   = 1'b0;
    buf_wr     = 1'b0;
    req_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // live_q keeps req_ready low for the first cycle after reset release
        req_ready = live_q;
        if (req_valid && live_q) begin
          awaddr_d = ADDR_W'(line_align(64'(wb_addr), LINE_WORDS));
          araddr_d = ADDR_W'(line_align(64'(req_addr), LINE_WORDS));
          buf_load = 1'b1;
          err_d    = 1'b0;
          state_d  = req_wb ? WB_AW : RD_AR;
        end
      end
      WB_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          cnt_d   = '0;
          state_d = WB_W;
        end
      end
      WB_W: begin
        wvalid = 1'b1;
        wlast  = is_last;
        if (wready) begin
          cnt_d = cnt_q + 1'b1;
          if (is_last) state_d = WB_B;
        end
      end
      WB_B: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = err_q | (bresp != AXI_RESP_OKAY);
          state_d = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          cnt_d   = '0;
          state_d = RD_R;
        end
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          // an early rlast or a missing final rlast both end the burst flagged
          err_d  = err_q | (rresp != AXI_RESP_OKAY) | (rlast != is_last);
          if (rlast || is_last) state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign awaddr    = awaddr_q;
  assign araddr    = araddr_q;
  assign awlen     = 8'(LINE_WORDS - 1);
  assign arlen     = 8'(LINE_WORDS - 1);
  assign awsize    = AXI_SIZE_WORD;
  assign arsize    = AXI_SIZE_WORD;
  assign awburst   = AXI_BURST_INCR;
  assign arburst   = AXI_BURST_INCR;
  assign wdata     = line[{cnt_q[IDX_W-1:0], 5'b0} +: 32];
  assign wstrb     = 4'hF;
  assign resp_data = line;
  assign resp_err  = err_q;

endmodule
